// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode selectors and a width helper
// used by both the single-clock and the dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Smallest r with 2**r >= n; a count of 0..depth needs
  // fifo_clog2(depth + 1) bits.
  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read, no reset.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (held when idle).
module sfifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [0:(1<<ADDR_SIZE)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with count, threshold flags, error pulses and
// optional first-word-fall-through read stage.
// Ports: i_clk, i_rst (sync, high); write i_wr_en/i_wr_data;
// read i_rd_en, o_rd_data, o_rd_valid; flags o_full, o_empty,
// o_almost_full, o_almost_empty, o_count; pulses o_overflow, o_underflow.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int ADDR_SIZE     = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DATA_SIZE-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [ADDR_SIZE:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int CW    = fifo_clog2(DEPTH + 1);
  localparam int PW    = ADDR_SIZE + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 ram_re;
  logic [DATA_SIZE-1:0] ram_q;
  logic [DATA_SIZE-1:0] hold;
  logic                 use_ram;

  assign wr_acc    = i_wr_en && !o_full;
  assign rd_acc    = i_rd_en && !o_empty;
  assign o_count   = count;
  // hold supplies the reset zero and, in FWFT, the bypassed word
  assign o_rd_data = use_ram ? ram_q : hold;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      wr_acc && !rd_acc: count_nxt = count + CW'(1);
      rd_acc && !wr_acc: count_nxt = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      count          <= '0;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      count          <= count_nxt;
      o_full         <= (count_nxt == DEPTH_C);
      o_almost_full  <= (count_nxt >= AF_C);
      o_almost_empty <= (count_nxt <= AE_C);
      o_overflow     <= i_wr_en && o_full;
      o_underflow    <= i_rd_en && o_empty;
    end
  end

  sfifo_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk    (i_clk),
    .wr_en  (wr_acc && !i_rst),
    .wr_addr(wr_ptr[ADDR_SIZE-1:0]),
    .wr_data(i_wr_data),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr[ADDR_SIZE-1:0]),
    .rd_data(ram_q)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    logic [PW-1:0] ram_cnt;
    logic          ram_has;
    logic          fetch;
    logic          bypass;

    // RAM q is the output register; o_empty tracks whether it holds
    // the head word, while count covers RAM plus that word.
    assign ram_cnt = wr_ptr - rd_ptr;
    assign ram_has = |ram_cnt;
    assign fetch   = (o_empty || rd_acc) && ram_has;
    // Popping the last word while a new one arrives: hand the write
    // straight to the output so streaming at count 1 has no bubble.
    assign bypass  = rd_acc && !ram_has && wr_acc;
    assign ram_re  = fetch && !i_rst;
    assign o_rd_valid = !o_empty;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rd_ptr  <= '0;
        o_empty <= 1'b1;
        use_ram <= 1'b0;
        hold    <= '0;
      end else begin
        if (fetch || bypass) rd_ptr <= rd_ptr + PW'(1);
        if (fetch) begin
          use_ram <= 1'b1;
          o_empty <= 1'b0;
        end else if (bypass) begin
          use_ram <= 1'b0;
          hold    <= i_wr_data;
          o_empty <= 1'b0;
        end else if (rd_acc) begin
          o_empty <= 1'b1;
        end
      end
    end
  end else begin : g_std
    assign ram_re = rd_acc && !i_rst;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rd_ptr     <= '0;
        o_empty    <= 1'b1;
        o_rd_valid <= 1'b0;
        use_ram    <= 1'b0;
        hold       <= '0;
      end else begin
        if (rd_acc) begin
          rd_ptr  <= rd_ptr + PW'(1);
          use_ram <= 1'b1;
        end
        o_rd_valid <= rd_acc;
        o_empty    <= (count_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft: one standard and one FWFT
// instance share the same stimulus, each against its own queue model.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] s_data, f_data;
  logic [4:0] s_count, f_count;
  logic s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  int passes = 0;
  int total  = 0;

  logic [7:0] qs[$];
  logic [7:0] qf[$];
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  bit         vf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(14),
    .AEMPTY_THRESH(2), .FWFT(0)
  ) u_std (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(s_data), .o_rd_valid(s_valid),
    .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_af),
    .o_almost_empty(s_ae), .o_count(s_count), .o_overflow(s_ovf),
    .o_underflow(s_unf)
  );

  sync_fifo_fwft #(
    .DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_THRESH(14),
    .AEMPTY_THRESH(2), .FWFT(1)
  ) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(f_data), .o_rd_valid(f_valid),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af),
    .o_almost_empty(f_ae), .o_count(f_count), .o_overflow(f_ovf),
    .o_underflow(f_unf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever a DUT delivers a word.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid) begin
        if (exp_s.size() == 0) chk("s_unexpected_word", s_data, -1);
        else chk("s_rd_data", s_data, exp_s.pop_front());
      end
      if (f_valid && rd_en) begin
        if (exp_f.size() == 0) chk("f_unexpected_pop", f_data, -1);
        else chk("f_rd_data", f_data, exp_f.pop_front());
      end
    end
  end

  task automatic step(input bit wr, input logic [7:0] d, input bit rd);
    int sb, fb;
    bit ws, rs, wf, rf, vis;
    wr_en = wr;
    wr_data = d;
    rd_en = rd;
    sb = qs.size();
    ws = wr && sb < 16;
    rs = rd && sb > 0;
    if (rs) exp_s.push_back(qs.pop_front());
    if (ws) qs.push_back(d);
    fb = qf.size();
    vis = vf;
    wf = wr && fb < 16;
    rf = rd && vis;
    if (rf) exp_f.push_back(qf.pop_front());
    if (wf) qf.push_back(d);
    // Head is shown once it sat in the FIFO over an edge, or
    // immediately when it replaces a popped last word.
    vf = ((fb - int'(rf)) > 0) || (rf && wf);
    @(posedge clk);
    #1;
    chk("s_count", s_count, qs.size());
    chk("s_full", s_full, qs.size() == 16);
    chk("s_empty", s_empty, qs.size() == 0);
    chk("s_almost_full", s_af, qs.size() >= 14);
    chk("s_almost_empty", s_ae, qs.size() <= 2);
    chk("s_overflow", s_ovf, wr && sb == 16);
    chk("s_underflow", s_unf, rd && sb == 0);
    chk("s_rd_valid", s_valid, rs);
    chk("f_count", f_count, qf.size());
    chk("f_full", f_full, qf.size() == 16);
    chk("f_empty", f_empty, !vf);
    chk("f_almost_full", f_af, qf.size() >= 14);
    chk("f_almost_empty", f_ae, qf.size() <= 2);
    chk("f_overflow", f_ovf, wr && fb == 16);
    chk("f_underflow", f_unf, rd && !vis);
    chk("f_rd_valid", f_valid, vf);
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    rst = 1'b1;
    wr_en = wr;
    rd_en = rd;
    wr_data = 8'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    qs.delete();
    qf.delete();
    exp_s.delete();
    exp_f.delete();
    vf = 1'b0;
    chk("rst_s_count", s_count, 0);
    chk("rst_s_flags", {s_empty, s_ae, s_full, s_af}, 4'b1100);
    chk("rst_s_pulses", {s_valid, s_ovf, s_unf}, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_f_count", f_count, 0);
    chk("rst_f_flags", {f_empty, f_ae, f_full, f_af}, 4'b1100);
    chk("rst_f_pulses", {f_valid, f_ovf, f_unf}, 0);
    chk("rst_f_data", f_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt;
    int pw, pr;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i <= 16; i++) step(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    repeat (17) step(1'b0, 8'h00, 1'b1);

    step(1'b1, 8'h30, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h31 + i), 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_a5_valid", f_valid, 1);
    chk("fwft_a5_data", f_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    vcnt = 0;
    for (int i = 1; i <= 11; i++) begin
      step(i <= 8, 8'(i), 1'b1);
      if (f_valid) vcnt++;
    end
    chk("fwft_stream_valid_cycles", vcnt, 8);

    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_reset_count", s_count, 7);
    do_reset(1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) begin
        pw = $urandom_range(20, 90);
        pr = $urandom_range(20, 90);
      end
      if (c == 450) do_reset($urandom_range(0, 1) == 1, 1'b1);
      step($urandom_range(0, 99) < pw, 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < pr);
    end
    repeat (20) step(1'b0, 8'h00, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    chk("s_scoreboard_drained", exp_s.size(), 0);
    chk("f_scoreboard_drained", exp_f.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. It adds occupancy count, programmable almost-full/almost-empty flags, sticky-free overflow/underflow pulses and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producers and consumers, for example stream re-timing and packet staging, where CDC logic is unnecessary.

## Interface
- DATA_SIZE, 8, data word width (≥1)
- ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE words (≥2)
- AFULL_THRESH, 14, o_almost_full asserts when count ≥ this value (1..depth)
- AEMPTY_THRESH, 2, o_almost_empty asserts when count ≤ this value (0..depth-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_SIZE  write data
- i_rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- o_rd_data  out  DATA_SIZE  read data
- o_rd_valid  out  1  o_rd_data holds a valid word
- o_full, o_empty  out  1  occupancy flags
- o_almost_full, o_almost_empty  out  1  threshold flags
- o_count  out  ADDR_SIZE+1  words held, 0..depth
- o_overflow, o_underflow  out  1  one-cycle pulse on a rejected write/read

## Operation
- Write accepted iff i_wr_en && !o_full. Read accepted iff i_rd_en && !o_empty. The flags are sampled before the edge; a write is never accepted against a read in the same cycle while the FIFO is full.
- Pointers wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide. The MSB is the wrap bit. Address = low ADDR_SIZE bits, modulo wrap, with no special case at depth-1 → 0.
- Count register: +1 on write only, −1 on read only, unchanged on both or neither. Never exceeds depth and never goes below 0.
- All flags are registered and derived from the next-state count:
  - full = (count == depth)
  - empty = (count == 0)
  - almost_full = (count ≥ AFULL_THRESH)
  - almost_empty = (count ≤ AEMPTY_THRESH)
- Standard mode: an accepted read at edge N drives o_rd_data and o_rd_valid=1 after edge N, for one cycle only. o_rd_data holds its last value otherwise.
- FWFT mode: a one-word output register is prefetched from RAM whenever it is empty and RAM holds data.
  - o_rd_valid = !o_empty.
  - o_rd_data shows the head word with no request.
  - An accepted i_rd_en pops it, and the next word appears the following cycle with no bubble if available.
  - o_count includes the output-register word.
- o_overflow = registered (i_wr_en && o_full). o_underflow = registered (i_rd_en && o_empty).
- Reset:
  - Pointers and count go to 0.
  - o_empty=1, o_almost_empty=1. o_full=0, o_almost_full=0.
  - o_rd_valid=0, o_overflow=0, o_underflow=0. o_rd_data=0.
  - RAM contents are not cleared.
  - Reset asserted mid-transfer discards all data. Requests during the reset cycle are ignored and raise no pulse.

## Timing
- Write at edge N: o_count and flags update after N.
  - Standard mode: o_empty falls after N.
  - FWFT mode: o_empty falls after N+1 (prefetch), and o_count is already 1 after N.
- Standard read latency: 1 cycle (request at N, data after N).
- FWFT: 0-cycle data visibility. Sustained 1 word/cycle with simultaneous read and write, including at count == 1.
- Error pulses are high for exactly the cycle after the offending request.

## Structure
- Package fifo_pkg holds:
  - mode constants FIFO_STD=0 and FIFO_FWFT=1
  - a count-width function clog2-style helper shared with the dual-clock FIFO
- Sub-module sfifo_ram: simple dual-port RAM with a synchronous write port and a synchronous read port. It has no reset and is parametrised by DATA_SIZE and ADDR_SIZE.
- The top level holds the pointers, count, flag registers and the FWFT output stage, selected by a generate on FWFT.

## Test plan
- Reset then idle with FIFO empty: o_empty=1, o_almost_empty=1, o_count=0, o_rd_valid=0.
- Fill past capacity: write 0x00..0x10 (17 words) at depth 16 → o_full after the 16th write, o_almost_full at count 14, one o_overflow pulse, o_count=16. Then read all → 0x00..0x0F in order, one o_underflow on an extra read.
- Wrap-around: write and read 40 words with occupancy kept at 3 → data order preserved across pointer wrap, o_count stays 3.
- Simultaneous read and write: at count=16, o_full=1 and write rejected; at count=1 the count stays 1 and data stays ordered.
- FWFT=1, single write 0xA5 → o_rd_valid=1 and o_rd_data=0xA5 two cycles after the write. Streaming 0x01..0x08 with i_rd_en held high produces 8 consecutive valid cycles.
- Assert i_rst at count=7 during active writes → next cycle o_count=0, o_empty=1, no error pulses, and subsequent reads return only post-reset data.
